// File: rtl/imem_bank_ctrl.sv
// Instruction-memory bank controller: 32-bit fetches assembled from four byte banks,
// plus a byte-serial program loader that writes the banks lane by lane.
module imem_bank_ctrl #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fetch_req,
    input  logic [AW+1:0] fetch_addr,
    output logic          fetch_ready,
    output logic          instr_valid,
    output logic [31:0]   instr,
    output logic          fetch_misalign,
    input  logic          load_start,
    input  logic [AW-1:0] load_base,
    input  logic          load_valid,
    input  logic [7:0]    load_byte,
    input  logic          load_last,
    output logic          load_ready,
    output logic [AW-1:0] bank_addr,
    input  logic [7:0]    bank_rdata0,
    input  logic [7:0]    bank_rdata1,
    input  logic [7:0]    bank_rdata2,
    input  logic [7:0]    bank_rdata3,
    output logic [3:0]    bank_we,
    output logic [7:0]    bank_wdata,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, FETCH, LOAD} state_t;

    state_t        state, state_next;
    logic [AW-1:0] fetch_word;
    logic [AW-1:0] word_ptr;
    logic [1:0]    lane;
    logic          misalign_q;
    logic          load_acc;

    assign load_acc = (state == LOAD) && load_valid;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (load_start)
                    state_next = LOAD;
                else if (fetch_req)
                    state_next = FETCH;
            end
            FETCH: state_next = IDLE;
            LOAD: begin
                if (load_acc && load_last)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Loader has priority over a simultaneous fetch; nothing is accepted while rst is high.
    assign fetch_ready = !rst && (state == IDLE) && !load_start;
    assign load_ready  = !rst && (state == LOAD);
    assign busy        = (state != IDLE);
    assign bank_addr   = (state == LOAD) ? word_ptr : fetch_word;

    always_comb begin
        bank_we    = '0;
        bank_wdata = '0;
        if (!rst && load_acc) begin
            bank_we[lane] = 1'b1;
            bank_wdata    = load_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            instr          <= '0;
            instr_valid    <= 1'b0;
            fetch_misalign <= 1'b0;
            fetch_word     <= '0;
            misalign_q     <= 1'b0;
            word_ptr       <= '0;
            lane           <= '0;
        end else begin
            state          <= state_next;
            instr_valid    <= 1'b0;
            fetch_misalign <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_start) begin
                        word_ptr <= load_base;
                        lane     <= '0;
                    end else if (fetch_req) begin
                        fetch_word <= fetch_addr[AW+1:2];
                        misalign_q <= |fetch_addr[1:0];
                    end
                end
                FETCH: begin
                    instr          <= {bank_rdata3, bank_rdata2, bank_rdata1, bank_rdata0};
                    instr_valid    <= 1'b1;
                    fetch_misalign <= misalign_q;
                end
                LOAD: begin
                    if (load_acc) begin
                        lane <= lane + 2'd1;
                        if (lane == 2'd3)
                            word_ptr <= word_ptr + AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_bank_ctrl.sv
// Bench for imem_bank_ctrl: behavioural byte banks plus a flat byte-array model of
// program memory; randomized loads and fetches are checked against that model.
module tb_imem_bank_ctrl;

    localparam int AW    = 8;
    localparam int WORDS = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          fetch_req;
    logic [AW+1:0] fetch_addr;
    logic          fetch_ready;
    logic          instr_valid;
    logic [31:0]   instr;
    logic          fetch_misalign;
    logic          load_start;
    logic [AW-1:0] load_base;
    logic          load_valid;
    logic [7:0]    load_byte;
    logic          load_last;
    logic          load_ready;
    logic [AW-1:0] bank_addr;
    logic [7:0]    bank_rdata0, bank_rdata1, bank_rdata2, bank_rdata3;
    logic [3:0]    bank_we;
    logic [7:0]    bank_wdata;
    logic          busy;

    logic [7:0] bank [4][WORDS];
    logic [7:0] model_mem [4*WORDS];
    int vectors = 0;
    int errors  = 0;
    logic seen_valid = 1'b0;

    imem_bank_ctrl #(.AW(AW)) dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
        .instr_valid(instr_valid), .instr(instr), .fetch_misalign(fetch_misalign),
        .load_start(load_start), .load_base(load_base), .load_valid(load_valid),
        .load_byte(load_byte), .load_last(load_last), .load_ready(load_ready),
        .bank_addr(bank_addr),
        .bank_rdata0(bank_rdata0), .bank_rdata1(bank_rdata1),
        .bank_rdata2(bank_rdata2), .bank_rdata3(bank_rdata3),
        .bank_we(bank_we), .bank_wdata(bank_wdata), .busy(busy)
    );

    always #5 clk = ~clk;

    assign bank_rdata0 = bank[0][bank_addr];
    assign bank_rdata1 = bank[1][bank_addr];
    assign bank_rdata2 = bank[2][bank_addr];
    assign bank_rdata3 = bank[3][bank_addr];

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (bank_we[i]) bank[i][bank_addr] = bank_wdata;
    end

    always @(negedge clk) if (instr_valid) seen_valid = 1'b1;

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; fetch_req = 0; fetch_addr = '0; load_start = 0; load_base = '0;
        load_valid = 0; load_byte = '0; load_last = 0;
        step(); step();
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || instr !== 32'h0 || instr_valid !== 1'b0 || fetch_misalign !== 1'b0 ||
            bank_we !== 4'h0 || bank_wdata !== 8'h0 || bank_addr !== 8'h0 ||
            fetch_ready !== 1'b1 || load_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: busy=%b instr=%h iv=%b mis=%b we=%b wd=%h ba=%h fr=%b lr=%b (want 0 0 0 0 0 0 0 1 0)",
                     busy, instr, instr_valid, fetch_misalign, bank_we, bank_wdata, bank_addr,
                     fetch_ready, load_ready);
        end
        step();
    endtask

    task automatic do_fetch(input logic [AW+1:0] addr);
        int w;
        logic [31:0] exp;
        logic mis;
        w   = int'(addr[AW+1:2]);
        exp = {model_mem[w*4+3], model_mem[w*4+2], model_mem[w*4+1], model_mem[w*4]};
        mis = |addr[1:0];
        fetch_req = 1'b1; fetch_addr = addr;
        @(negedge clk);
        vectors++;
        if (fetch_ready !== 1'b1) begin
            errors++; $display("FAIL fetch_ready_idle: got %b want 1", fetch_ready);
        end
        step();
        fetch_req = 1'b0; fetch_addr = AW'($urandom);
        @(negedge clk);
        vectors++;
        if (busy !== 1'b1 || fetch_ready !== 1'b0 || instr_valid !== 1'b0 || bank_addr !== AW'(w)) begin
            errors++;
            $display("FAIL fetch_cycle: busy=%b fr=%b iv=%b ba=%h want 1 0 0 %h",
                     busy, fetch_ready, instr_valid, bank_addr, w);
        end
        step();
        @(negedge clk);
        vectors++;
        if (instr_valid !== 1'b1 || instr !== exp || fetch_misalign !== mis) begin
            errors++;
            $display("FAIL fetch_data addr=%h: iv=%b instr=%h mis=%b want 1 %h %b",
                     addr, instr_valid, instr, fetch_misalign, exp, mis);
        end
        step();
        @(negedge clk);
        vectors++;
        if (instr_valid !== 1'b0 || fetch_misalign !== 1'b0 || busy !== 1'b0 ||
            instr !== exp || bank_addr !== AW'(w)) begin
            errors++;
            $display("FAIL fetch_hold: iv=%b mis=%b busy=%b instr=%h ba=%h want 0 0 0 %h %h",
                     instr_valid, fetch_misalign, busy, instr, bank_addr, exp, w);
        end
        step();
    endtask

    // Streams bytes into an already-entered LOAD; abort_at >= 0 asserts rst on that byte.
    task automatic load_stream(input int base, input logic [7:0] data[$], input bit gaps, input int abort_at);
        int word, ln;
        for (int k = 0; k < data.size(); k++) begin
            word = (base + k / 4) % WORDS;
            ln   = k % 4;
            if (gaps) begin
                for (int g = 0; g < 3 && $urandom_range(0, 2) == 0; g++) begin
                    load_valid = 1'b0; load_byte = 8'($urandom);
                    @(negedge clk);
                    vectors++;
                    if (bank_we !== 4'h0 || load_ready !== 1'b1 || busy !== 1'b1) begin
                        errors++;
                        $display("FAIL load_gap: we=%b lr=%b busy=%b want 0 1 1", bank_we, load_ready, busy);
                    end
                    step();
                end
            end
            load_valid = 1'b1; load_byte = data[k]; load_last = (k == data.size() - 1);
            load_start = 1'($urandom);
            if (k == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                vectors++;
                if (bank_we !== 4'h0) begin
                    errors++; $display("FAIL abort_we: got %b want 0000", bank_we);
                end
                step();
                rst = 1'b0; load_valid = 1'b0; load_last = 1'b0; load_start = 1'b0;
                @(negedge clk);
                vectors++;
                if (busy !== 1'b0 || load_ready !== 1'b0 || fetch_ready !== 1'b1 ||
                    bank_we !== 4'h0 || bank_addr !== 8'h0) begin
                    errors++;
                    $display("FAIL abort_state: busy=%b lr=%b fr=%b we=%b ba=%h want 0 0 1 0 00",
                             busy, load_ready, fetch_ready, bank_we, bank_addr);
                end
                step();
                return;
            end
            @(negedge clk);
            vectors++;
            if (bank_we !== (4'b0001 << ln) || bank_addr !== AW'(word) || bank_wdata !== data[k]) begin
                errors++;
                $display("FAIL load_write k=%0d: we=%b ba=%h wd=%h want %b %h %h",
                         k, bank_we, bank_addr, bank_wdata, 4'b0001 << ln, word, data[k]);
            end
            model_mem[word*4+ln] = data[k];
            step();
        end
        load_valid = 1'b0; load_last = 1'b0; load_start = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || bank_we !== 4'h0 || load_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_done: busy=%b we=%b lr=%b want 0 0 0", busy, bank_we, load_ready);
        end
        step();
    endtask

    task automatic do_load(input int base, input logic [7:0] data[$], input bit gaps, input int abort_at);
        load_start = 1'b1; load_base = AW'(base);
        @(negedge clk);
        vectors++;
        if (fetch_ready !== 1'b0 || load_ready !== 1'b0) begin
            errors++; $display("FAIL load_start: fr=%b lr=%b want 0 0", fetch_ready, load_ready);
        end
        step();
        load_base = AW'($urandom);
        load_stream(base, data, gaps, abort_at);
    endtask

    task automatic test_known_fetch();
        model_mem[20] = 8'h13; model_mem[21] = 8'h00; model_mem[22] = 8'h50; model_mem[23] = 8'h00;
        bank[0][5] = 8'h13; bank[1][5] = 8'h00; bank[2][5] = 8'h50; bank[3][5] = 8'h00;
        do_fetch(10'h014);
        vectors++;
        if (instr !== 32'h00500013) begin
            errors++; $display("FAIL known_fetch: got %h want 00500013", instr);
        end
        do_fetch(10'h016);
    endtask

    task automatic test_load_basic();
        logic [7:0] d[$];
        d = '{8'h93, 8'h00, 8'h10, 8'h00};
        do_load(32'h10, d, 1'b0, -1);
        do_fetch(10'h040);
        vectors++;
        if (instr !== 32'h00100093) begin
            errors++; $display("FAIL load_basic_fetch: got %h want 00100093", instr);
        end
    endtask

    task automatic test_collision();
        logic [7:0] d[$];
        d = '{8'($urandom), 8'($urandom)};
        seen_valid = 1'b0;
        load_start = 1'b1; load_base = 8'h30; fetch_req = 1'b1; fetch_addr = 10'h100;
        @(negedge clk);
        vectors++;
        if (fetch_ready !== 1'b0) begin
            errors++; $display("FAIL collision_ready: got %b want 0", fetch_ready);
        end
        step();
        fetch_req = 1'b0;
        load_stream(32'h30, d, 1'b1, -1);
        step();
        vectors++;
        if (seen_valid !== 1'b0) begin
            errors++; $display("FAIL collision_no_fetch: instr_valid seen=%b want 0", seen_valid);
        end
        do_fetch(10'h0C0);
    endtask

    task automatic test_wrap();
        logic [7:0] d[$];
        for (int i = 0; i < 8; i++) d.push_back(8'($urandom));
        do_load(32'hFF, d, 1'b1, -1);
        do_fetch(10'h3FC);
        do_fetch(10'h000);
    endtask

    task automatic test_reset_abort();
        logic [7:0] d[$];
        for (int i = 0; i < 6; i++) d.push_back(8'($urandom));
        do_load(32'h50, d, 1'b0, 2);
        d = '{8'hA5};
        do_load(32'h60, d, 1'b0, -1);
        do_fetch(10'h140);
        do_fetch(10'h180);
        // Reset in the FETCH cycle must swallow the pending pulse and clear instr.
        seen_valid = 1'b0;
        fetch_req = 1'b1; fetch_addr = 10'h044;
        step();
        fetch_req = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        step(); step();
        vectors++;
        if (seen_valid !== 1'b0 || instr !== 32'h0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL fetch_abort: seen_iv=%b instr=%h busy=%b want 0 0 0", seen_valid, instr, busy);
        end
    endtask

    task automatic test_random();
        logic [7:0] d[$];
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                d.delete();
                for (int i = 0; i < int'($urandom_range(1, 9)); i++) d.push_back(8'($urandom));
                do_load(int'($urandom_range(0, WORDS - 1)), d, 1'b1, -1);
            end else begin
                do_fetch(10'($urandom));
            end
        end
    endtask

    initial begin
        for (int w = 0; w < WORDS; w++)
            for (int l = 0; l < 4; l++) begin
                bank[l][w] = 8'($urandom);
                model_mem[w*4+l] = bank[l][w];
            end
        test_reset();
        test_known_fetch();
        test_load_basic();
        test_collision();
        test_wrap();
        test_reset_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
